dec_onehot_seq: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with valid/ready handshakes on both sides and an optional scan mode. It decodes a SEL_W-bit select into a 2**SEL_W-bit one-hot word and presents it as a pipelined output beat. In scan mode it emits every output position in turn, starting from the requested select and wrapping. It is the general-width, flow-controlled successor to the fixed 3-to-8 combinational decoder. It drives strobe/enable fan-out for downstream channel logic.

---
 rtl/dec_onehot_seq.sv | 179 +++++++++++++++++
 tb/tb_dec_onehot_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered binary-to-one-hot decoder with valid/ready
// handshakes on both sides. The beat is held in a single output register.
// Optional feature macro: DEC_SCAN_EN. When it is defined, a request with
// scan=1 emits all OUT_W positions in turn, starting at sel and wrapping.
// When it is undefined, the block is a plain registered direct decoder:
// scan is ignored and busy is tied low.
// SEL_W is intended to be in the range 1..6.
module dec_onehot_seq #(
  parameter int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan,
  output logic [OUT_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // Output beat register: y is one-hot while out_valid_q is high, zero otherwise.
  logic [OUT_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;

  // One-hot image of the incoming select. It only reaches the outputs
  // through the register, so there is no combinational in->out path.
  logic [OUT_W-1:0] sel_onehot;
  logic             consume;
  logic             accept;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_sel_dec
      assign sel_onehot[gi] = (sel == SEL_W'(gi));
    end
  endgenerate

  assign consume   = out_valid_q && out_ready;
  assign y         = y_q;
  assign out_valid = out_valid_q;

`ifdef DEC_SCAN_EN

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] pos_q, pos_d;
  logic [SEL_W:0]   cnt_q, cnt_d;   // one bit wider so it can hold OUT_W
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] pos_inc;
  logic [OUT_W-1:0] pos_onehot;
  logic             last_beat;

  // The position wraps naturally at SEL_W bits (OUT_W-1 goes to 0).
  assign pos_inc   = pos_q + SEL_W'(1);
  assign last_beat = (cnt_q == (SEL_W + 1)'(OUT_W));
  assign busy      = busy_q;

  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_pos_dec
      assign pos_onehot[gi] = (pos_inc == SEL_W'(gi));
    end
  endgenerate

  // Next-state, handshake and output-register logic for the IDLE/SCAN controller.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          // A new beat replaces any beat consumed on this same edge, so there is no bubble.
          y_d         = sel_onehot;
          out_valid_d = 1'b1;
          if (scan) begin
            pos_d   = sel;
            cnt_d   = (SEL_W + 1)'(1);
            busy_d  = 1'b1;
            state_d = SCAN;
          end
        end else if (consume) begin
          y_d         = '0;
          out_valid_d = 1'b0;
        end
      end

      SCAN: begin
        // The input side stays closed until the whole sequence has been consumed.
        if (consume) begin
          if (last_beat) begin
            y_d         = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            pos_d = pos_inc;
            y_d   = pos_onehot;
            cnt_d = cnt_q + (SEL_W + 1)'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending beat or scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

`else

  // Scan is not built in, so the request's scan flag has no effect.
  logic unused_scan;
  assign unused_scan = scan;
  assign busy        = 1'b0;

  // Direct decode: load on acceptance, clear when consumed with nothing new behind it.
  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    if (accept) begin
      y_d         = sel_onehot;
      out_valid_d = 1'b1;
    end else if (consume) begin
      y_d         = '0;
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset drops any pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

`endif

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq. The driver pushes the beats each
// accepted request should produce. The monitor checks every cycle against
// the head of that queue and pops it when the beat is consumed.
module tb_dec_onehot_seq;

  localparam int SEL_W = 3;
  localparam int OUT_W = 2 ** SEL_W;
`ifdef DEC_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             scan;
  logic [OUT_W-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  dec_onehot_seq #(.SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .scan(scan), .y(y), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic [OUT_W-1:0] y;
    bit               scan;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    rdy_mode = 0;      // 0: ready high, 1: ready low, 2: random, 3: manual
  bit    manual_ready = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The reference model lists the beats a request should produce.
  task automatic push_model(input int s, input bit sc);
    beat_t b;
    if (sc && SCAN_EN) begin
      for (int k = 0; k < OUT_W; k++) begin
        b.y = '0;
        b.y[(s + k) % OUT_W] = 1'b1;
        b.scan = 1'b1;
        exp_q.push_back(b);
      end
    end else begin
      b.y = '0;
      b.y[s % OUT_W] = 1'b1;
      b.scan = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  // Drive out_ready 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      2: out_ready = ($urandom % 3) != 0;
      default: out_ready = manual_ready;
    endcase
  end

  // Check the outputs on the falling edge, then pop the beat if it is consumed.
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_valid;
    exp_valid = exp_q.size() != 0;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("y", 64'(y), 64'(exp_q[0].y));
      chk("busy", 64'(busy), 64'(exp_q[0].scan));
      exp_busy = exp_q[0].scan;
    end else begin
      chk("y_idle", 64'(y), 64'(0));
      chk("busy_idle", 64'(busy), 64'(0));
      exp_busy = 1'b0;
    end
    chk("in_ready", 64'(in_ready), 64'(!exp_busy && (!exp_valid || out_ready)));
    if (!rst && out_valid && out_ready && exp_valid)
      void'(exp_q.pop_front());
  end

  // Send one request and hold it until it is accepted.
  // The task is entered and left at rising edge + 1.
  task automatic send(input int s, input bit sc);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    in_valid = 1'b1;
    sel = s[SEL_W-1:0];
    scan = sc;
    while (!done && t < 500) begin
      @(negedge clk); #1;
      if (in_ready && !rst) begin
        push_model(s, sc);
        done = 1'b1;
      end
      t++;
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'(done), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    idle(1);
  endtask

  initial begin
    // Reset for 2 cycles with a request present; nothing may be accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    sel = 3'd5;
    scan = 1'b0;
    out_ready = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Direct decode, then three back-to-back requests with no bubble.
    send(5, 1'b0);
    send(0, 1'b0);
    send(7, 1'b0);
    send(3, 1'b0);
    wait_drain();

    // Backpressure: the beat must stay stable while out_ready is low.
    rdy_mode = 3;
    manual_ready = 1'b0;
    send(2, 1'b0);
    idle(4);
    manual_ready = 1'b1;
    idle(2);
    rdy_mode = 0;
    wait_drain();

    // Scan sequence starting at 6 and wrapping.
    send(6, 1'b1);
    wait_drain();

    // Reset in the middle of a scan, after three beats have been consumed.
    rdy_mode = 3;
    manual_ready = 1'b1;
    send(0, 1'b1);
    idle(3);
    manual_ready = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("midscan_rst_y", 64'(y), 64'(0));
    chk("midscan_rst_valid", 64'(out_valid), 64'(0));
    chk("midscan_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    rst = 1'b0;
    manual_ready = 1'b1;
    idle(1);
    send(1, 1'b0);
    rdy_mode = 0;
    wait_drain();

    // Random requests, scans and output stalls.
    rdy_mode = 2;
    for (int i = 0; i < 250; i++) begin
      send($urandom_range(0, OUT_W - 1), ($urandom % 4) == 0);
      if ($urandom % 4 == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
